// File: rtl/add16_pkg.sv
// Shared types for the adder16 result stage: flag layout and the FIFO entry format.
package add16_pkg;

  localparam int FLAG_W      = 5;
  localparam int FLAG_SIGN   = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_PARITY = 3;
  localparam int FLAG_OVF    = 4;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef struct packed {
    logic [15:0] sum;
    flags_t      flags;
  } add16_entry_t;

endpackage

// File: rtl/add16_fifo.sv
// DEPTH-entry FIFO of add16_entry_t with occupancy counter and async active-low reset.
// Only the control state is reset; storage contents are qualified by occupancy.
module add16_fifo
  import add16_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  add16_entry_t     wdata,
  output add16_entry_t     rdata,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  add16_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (occupancy == OCC_W'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/add16_result_stage.sv
// Result/flag capture stage behind adder16: handshake FIFO, sticky flags, overflow counter.
// Optional macro ADD16_FLAG_CHECK_EN enables the sign/zero/parity consistency check (flag_err).
module add16_result_stage
  import add16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_parity,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [4:0]       out_flags,
  output logic [4:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_count,
  output logic             flag_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] OVF_MAX = '1;

  flags_t           in_flags;
  add16_entry_t     wr_entry;
  add16_entry_t     head;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  always_comb begin
    in_flags              = '0;
    in_flags[FLAG_SIGN]   = in_sign;
    in_flags[FLAG_ZERO]   = in_zero;
    in_flags[FLAG_CARRY]  = in_carry;
    in_flags[FLAG_PARITY] = in_parity;
    in_flags[FLAG_OVF]    = in_overflow;
  end

  assign wr_entry = '{sum: in_sum, flags: in_flags};

  // Handshake depends only on registered occupancy, never on out_ready.
  assign in_ready  = !full;
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_sum   = empty ? 16'h0000 : head.sum;
  assign out_flags = empty ? '0 : head.flags;

  add16_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_entry),
    .rdata     (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  // A clear coinciding with a push keeps only the pushed contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
      ovf_count    <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? in_flags : '0;
      ovf_count    <= (push && in_overflow) ? CNT_W'(1) : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
      if (in_overflow && (ovf_count != OVF_MAX)) ovf_count <= ovf_count + CNT_W'(1);
    end
  end

`ifdef ADD16_FLAG_CHECK_EN
  logic mismatch;

  assign mismatch = (in_sign != in_sum[15]) ||
                    (in_zero != ~|in_sum) ||
                    (in_parity != ~^in_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_err <= 1'b0;
    end else if (sticky_clr) begin
      flag_err <= push && mismatch;
    end else if (push && mismatch) begin
      flag_err <= 1'b1;
    end
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_add16_result_stage.sv
// Randomized self-checking bench for add16_result_stage against a queue-based reference model.
module tb_add16_result_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_sum;
  logic             in_sign, in_zero, in_carry, in_parity, in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [4:0]       out_flags;
  logic [4:0]       sticky_flags;
  logic             sticky_clr;
  logic [CNT_W-1:0] ovf_count;
  logic             flag_err;

  int tests  = 0;
  int errors = 0;

  // Reference model state: queue of {sum, flags}.
  logic [20:0] m_q[$];
  logic [4:0]  m_sticky;
  int          m_ovf;
  logic        m_err;

  always #5 clk = ~clk;

  add16_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_sign      (in_sign),
    .in_zero      (in_zero),
    .in_carry     (in_carry),
    .in_parity    (in_parity),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .ovf_count    (ovf_count),
    .flag_err     (flag_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags an ideal adder would report for sum s: {ovf, parity, carry, zero, sign}.
  function automatic logic [4:0] true_flags(input logic [15:0] s, input logic c, input logic v);
    logic even;
    even = ($countones(s) % 2) == 0;
    return {v, even, c, (s == 16'h0000), s[15]};
  endfunction

  function automatic logic check_bad(input logic [15:0] s, input logic [4:0] f);
    logic [4:0] t;
    t = true_flags(s, 1'b0, 1'b0);
    return (f[0] != t[0]) || (f[1] != t[1]) || (f[3] != t[3]);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sticky = '0;
    m_ovf    = 0;
    m_err    = 1'b0;
  endtask

  task automatic check_all();
    logic [20:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : 21'h0;
    chk("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("out_sum",   32'(out_sum),   32'(hd[20:5]));
    chk("out_flags", 32'(out_flags), 32'(hd[4:0]));
    chk("sticky",    32'(sticky_flags), 32'(m_sticky));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
`ifdef ADD16_FLAG_CHECK_EN
    chk("flag_err",  32'(flag_err),  32'(m_err));
`else
    chk("flag_err",  32'(flag_err),  32'(1'b0));
`endif
  endtask

  // Drive one cycle's inputs (called at negedge), advance the model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [15:0] s, input logic [4:0] f,
                      input logic ordy, input logic clr);
    logic push, pop;
    in_valid    = v;
    in_sum      = s;
    in_sign     = f[0];
    in_zero     = f[1];
    in_carry    = f[2];
    in_parity   = f[3];
    in_overflow = f[4];
    out_ready   = ordy;
    sticky_clr  = clr;
    @(posedge clk);
    push = v && (m_q.size() < DEPTH);
    pop  = ordy && (m_q.size() != 0);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({s, f});
    if (clr) begin
      m_sticky = push ? f : 5'h0;
      m_ovf    = (push && f[4]) ? 1 : 0;
      m_err    = push && check_bad(s, f);
    end else if (push) begin
      m_sticky = m_sticky | f;
      if (f[4] && m_ovf < OVF_MAX) m_ovf++;
      if (check_bad(s, f)) m_err = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [15:0] s;
    logic [4:0]  f;
    rst_n = 1'b0;
    in_valid = 0; in_sum = 0; in_sign = 0; in_zero = 0; in_carry = 0;
    in_parity = 0; in_overflow = 0; out_ready = 0; sticky_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    // 7FFF + 0001: first-entry latency and counters.
    step(1, 16'h8000, 5'h11, 1, 0);
    chk("first_sum", 32'(out_sum), 32'h8000);
    chk("first_ovf", 32'(ovf_count), 32'd1);
    step(0, 0, 0, 1, 0);

    // Fill to DEPTH with downstream stalled, then drain in order.
    step(1, 16'h0000, 5'h0E, 0, 0);
    step(1, 16'h1234, 5'h08, 0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("drain_order", 32'(out_sum), 32'h1234);
    step(0, 0, 0, 1, 0);

    // Overflow counter saturation, then clear together with an overflow push.
    for (int i = 0; i < 300; i++) step(1, 16'h8001, true_flags(16'h8001, 1'b0, 1'b1), 1, 0);
    chk("ovf_sat", 32'(ovf_count), 32'(OVF_MAX));
    step(1, 16'h8001, true_flags(16'h8001, 1'b0, 1'b1), 1, 1);
    chk("ovf_clr_push", 32'(ovf_count), 32'd1);

    // Clear coinciding with a push keeps only the pushed flags.
    step(1, 16'h0003, 5'h04 | true_flags(16'h0003, 1'b0, 1'b0), 1, 1);
    chk("sticky_clr_push", 32'(sticky_flags), 32'h0C);

    // Flag consistency: zero flag wrong for a zero sum.
    step(1, 16'h0000, 5'h08, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);

    // Asynchronous reset mid-stream with two entries held.
    step(1, 16'hA5A5, true_flags(16'hA5A5, 1'b1, 1'b1), 0, 0);
    step(1, 16'h5A5A, true_flags(16'h5A5A, 1'b0, 1'b0), 0, 0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sticky", 32'(sticky_flags), 32'd0);
    chk("arst_ovf", 32'(ovf_count), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Randomized traffic, mostly consistent flags.
    for (int i = 0; i < 2000; i++) begin
      s = 16'($urandom);
      if ($urandom_range(0, 3) == 0) s = 16'h0000;
      f = true_flags(s, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) f = 5'($urandom);
      step(1'($urandom), s, f, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
